// File: rtl/ipf_lcu_feeder_if.sv
// Bundles the frame-buffer, parameter-memory and IPF pixel-port signals of the LCU feeder.
// The master modport is the feeder's view; the slave modport is the memories and IPF core.
interface ipf_lcu_feeder_if #(
    parameter int AW = 14
);
    logic          img_rd;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_q;
    logic          par_rd;
    logic [5:0]    par_addr;
    logic [23:0]   par_q;
    logic          busy;
    logic          in_en;
    logic [7:0]    din;
    logic [1:0]    ipf_type;
    logic [4:0]    ipf_band_pos;
    logic          ipf_wo_class;
    logic [15:0]   ipf_offset;
    logic [2:0]    lcu_x;
    logic [2:0]    lcu_y;
    logic [1:0]    lcu_size;
    logic          done;

    modport master (
        output img_rd, img_addr, par_rd, par_addr,
        output in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
        output lcu_x, lcu_y, lcu_size, done,
        input  img_q, par_q, busy
    );

    modport slave (
        input  img_rd, img_addr, par_rd, par_addr,
        input  in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
        input  lcu_x, lcu_y, lcu_size, done,
        output img_q, par_q, busy
    );
endinterface

// File: rtl/ipf_lcu_feeder.sv
// Streams a square raster frame into the IPF pixel port in LCU order, fetching each
// LCU's parameter word just ahead of its pixels and buffering reads against IPF busy.
module ipf_lcu_feeder #(
    parameter int IMG_W = 128,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cfg_lcu_size,
    ipf_lcu_feeder_if.master bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int BW = 2 * (CW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAR,
        S_PWAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]    size_q;
    logic [2:0]    cur_x, cur_y;
    logic [2:0]    lcu_x_q, lcu_y_q;
    logic [1:0]    type_q;
    logic [4:0]    band_q;
    logic          wo_q;
    logic [15:0]   offset_q;

    logic [CW-1:0] px, py;
    logic          all_issued;
    logic [BW-1:0] acc_cnt;
    logic          rd_pend;

    logic          out_valid;
    logic [7:0]    out_data;
    logic [7:0]    skid0, skid1;
    logic [1:0]    skid_cnt;

    logic [2:0]    sh, rsh, occ, row_m1;
    logic [CW-1:0] l_m1, row, col;
    logic [BW-1:0] lsq_m1;
    logic          accept, issue, lcu_last_beat, last_lcu;
    logic          take, from_skid, from_mem, push;

    // LCU geometry follows from the latched size code: L = 16 << size_q.
    assign sh     = 3'd4 + {1'b0, size_q};
    assign rsh    = 3'(CW) - sh;
    assign l_m1   = (CW'(1) << sh) - CW'(1);
    assign lsq_m1 = (BW'(1) << {sh, 1'b0}) - BW'(1);
    assign row_m1 = 3'((IMG_W >> sh) - 1);

    assign row = (CW'(cur_y) << sh) + py;
    assign col = (CW'(cur_x) << sh) + px;

    assign accept        = out_valid && !bus.busy;
    assign last_lcu      = (cur_x == row_m1) && (cur_y == row_m1);
    assign lcu_last_beat = (state == S_STREAM) && accept && (acc_cnt == lsq_m1);

    // Reads are only issued while output register + skid + the in-flight read can absorb them.
    assign occ   = 3'(out_valid) + 3'(skid_cnt) + 3'(rd_pend);
    assign issue = ((state == S_PWAIT) || (state == S_STREAM)) && !all_issued && (occ < 3'd3);

    assign take      = !out_valid || accept;
    assign from_skid = take && (skid_cnt != 2'd0);
    assign from_mem  = take && (skid_cnt == 2'd0) && rd_pend;
    assign push      = rd_pend && !from_mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_PAR;
            S_PAR:    state_nxt = S_PWAIT;
            S_PWAIT:  state_nxt = S_STREAM;
            S_STREAM: if (lcu_last_beat) state_nxt = last_lcu ? S_DONE : S_PAR;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // cur_x/cur_y point at the LCU being fetched; lcu_x/lcu_y follow them only once its parameters land.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_q   <= 2'd0;
            cur_x    <= 3'd0;
            cur_y    <= 3'd0;
            lcu_x_q  <= 3'd0;
            lcu_y_q  <= 3'd0;
            type_q   <= 2'd0;
            band_q   <= 5'd0;
            wo_q     <= 1'b0;
            offset_q <= 16'd0;
        end else begin
            if (state == S_IDLE && start) begin
                size_q  <= (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
                cur_x   <= 3'd0;
                cur_y   <= 3'd0;
                lcu_x_q <= 3'd0;
                lcu_y_q <= 3'd0;
            end
            if (state == S_PWAIT) begin
                type_q   <= bus.par_q[23:22];
                band_q   <= bus.par_q[21:17];
                wo_q     <= bus.par_q[16];
                offset_q <= bus.par_q[15:0];
                lcu_x_q  <= cur_x;
                lcu_y_q  <= cur_y;
            end
            if (lcu_last_beat && !last_lcu) begin
                if (cur_x == row_m1) begin
                    cur_x <= 3'd0;
                    cur_y <= cur_y + 3'd1;
                end else begin
                    cur_x <= cur_x + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px         <= '0;
            py         <= '0;
            all_issued <= 1'b0;
            acc_cnt    <= '0;
        end else if (state == S_PAR) begin
            px         <= '0;
            py         <= '0;
            all_issued <= 1'b0;
            acc_cnt    <= '0;
        end else begin
            if (issue) begin
                if (px == l_m1) begin
                    px <= '0;
                    if (py == l_m1) begin
                        all_issued <= 1'b1;
                    end else begin
                        py <= py + CW'(1);
                    end
                end else begin
                    px <= px + CW'(1);
                end
            end
            if (accept) begin
                acc_cnt <= acc_cnt + BW'(1);
            end
        end
    end

    // Output register is the head of a 3-deep queue; skid0 is always the oldest buffered pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            skid0     <= 8'd0;
            skid1     <= 8'd0;
            skid_cnt  <= 2'd0;
        end else begin
            rd_pend <= issue;
            if (take) begin
                out_valid <= from_skid || from_mem;
                if (from_skid) begin
                    out_data <= skid0;
                end else if (from_mem) begin
                    out_data <= bus.img_q;
                end
            end
            case ({from_skid, push})
                2'b10: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b01: begin
                    if (skid_cnt == 2'd0) begin
                        skid0 <= bus.img_q;
                    end else begin
                        skid1 <= bus.img_q;
                    end
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= bus.img_q;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= bus.img_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.img_rd       = issue;
    assign bus.img_addr     = AW'(row) * AW'(IMG_W) + AW'(col);
    assign bus.par_rd       = (state == S_PAR);
    assign bus.par_addr     = (6'(cur_y) << rsh) + 6'(cur_x);
    assign bus.in_en        = out_valid;
    assign bus.din          = out_data;
    assign bus.ipf_type     = type_q;
    assign bus.ipf_band_pos = band_q;
    assign bus.ipf_wo_class = wo_q;
    assign bus.ipf_offset   = offset_q;
    assign bus.lcu_x        = lcu_x_q;
    assign bus.lcu_y        = lcu_y_q;
    assign bus.lcu_size     = size_q;
    assign bus.done         = (state == S_DONE);
endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Self-checking bench for ipf_lcu_feeder: models the frame/parameter memories and compares
// every accepted beat against an LCU-order address model derived from plain arithmetic.
module tb_ipf_lcu_feeder;
    localparam int IMG_W = 128;
    localparam int NPIX  = IMG_W * IMG_W;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cfg_lcu_size;
    int         checks   = 0;
    int         failures = 0;

    ipf_lcu_feeder_if #(.AW(14)) bus ();

    ipf_lcu_feeder #(.IMG_W(IMG_W), .AW(14)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .bus          (bus)
    );

    logic [7:0]  img_mem [NPIX];
    logic [23:0] par_mem [64];
    logic [7:0]  acc_din [NPIX];
    logic [2:0]  acc_lx  [NPIX];
    logic [2:0]  acc_ly  [NPIX];

    always #5 clk = ~clk;

    // Synchronous-read memories: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.img_rd) bus.img_q <= img_mem[bus.img_addr];
        if (bus.par_rd) bus.par_q <= par_mem[bus.par_addr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {bus.img_rd, bus.img_addr, bus.par_rd, bus.par_addr, bus.in_en, bus.din,
                bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset,
                bus.lcu_x, bus.lcu_y, bus.lcu_size, bus.done};
    endfunction

    function automatic logic [38:0] ipf_side();
        return {bus.in_en, bus.din, bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class,
                bus.ipf_offset, bus.lcu_x, bus.lcu_y};
    endfunction

    // Beat k of the frame: which LCU it belongs to and which raster address it comes from.
    function automatic void modelBeat(input int k, input int lsz, output int addr,
                                      output int lcu, output int lx, output int ly);
        int n, b, w;
        n    = IMG_W / lsz;
        b    = lsz * lsz;
        lcu  = k / b;
        w    = k % b;
        lx   = lcu % n;
        ly   = lcu / n;
        addr = (ly * lsz + w / lsz) * IMG_W + lx * lsz + w % lsz;
    endfunction

    task automatic countQuiet(input int ncyc, output int active);
        active = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.img_rd || bus.par_rd || bus.in_en || bus.done) active++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] cfg, input int busy_pct,
                                 input int abort_at, input int glitch_at);
        int lsz, nl, eff, acc_n, cyc, gap, done_cnt, par_cnt, rd_cnt, last_addr, extra, quiet;
        int din_err, fld_err, stab_err, gap_err, bnd_err, paddr_err, done_err;
        int addr, lcu, lx, ly, prev_lx, prev_ly, prev_off;
        bit was_stall, acc_prev, finished, aborted, glitched;
        logic [38:0] snap;

        eff = (cfg == 2'd3) ? 2 : int'(cfg);
        lsz = 16 << eff;
        nl  = (IMG_W / lsz) * (IMG_W / lsz);
        {acc_n, gap, done_cnt, par_cnt, rd_cnt, last_addr, extra} = '0;
        {din_err, fld_err, stab_err, gap_err, bnd_err, paddr_err, done_err} = '0;
        {prev_lx, prev_ly, prev_off} = '0;
        {was_stall, acc_prev, finished, aborted, glitched} = '0;
        snap = '0;

        @(negedge clk);
        cfg_lcu_size = cfg;
        start        = 1'b1;
        bus.busy     = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!finished && !aborted && cyc < 70000) begin
            if (cyc == 1) checkOutput({tag, "_par_rd_first"}, 64'({bus.par_rd, bus.par_addr}), 64'({1'b1, 6'd0}));
            if (cyc == 2) checkOutput({tag, "_img_rd_first"}, 64'({bus.img_rd, bus.img_addr}), 64'({1'b1, 14'd0}));
            if (cyc == 3) checkOutput({tag, "_params_first"}, 64'({bus.in_en, bus.ipf_offset, bus.lcu_x, bus.lcu_y}),
                                      64'({1'b0, 16'hA500, 3'd0, 3'd0}));
            if (cyc == 4) checkOutput({tag, "_beat_first"}, 64'({bus.in_en, bus.din}), 64'({1'b1, img_mem[0]}));

            if (bus.par_rd) begin
                if (bus.par_addr !== 6'(par_cnt)) paddr_err++;
                par_cnt++;
            end
            if (bus.img_rd) begin
                rd_cnt++;
                last_addr = int'(bus.img_addr);
            end
            if (was_stall && ipf_side() !== snap) stab_err++;

            if (bus.done) begin
                done_cnt++;
                if (bus.in_en !== 1'b0 || !acc_prev || acc_n != NPIX) done_err++;
                finished = 1'b1;
            end else if (busy_pct == 0 && acc_n > 0 && acc_n < NPIX && !bus.in_en) begin
                gap++;
                modelBeat(acc_n, lsz, addr, lcu, lx, ly);
                if (gap <= 2 && {bus.lcu_x, bus.lcu_y, bus.ipf_offset} !== {3'(prev_lx), 3'(prev_ly), 16'(prev_off)})
                    bnd_err++;
                if (gap == 3 && {bus.lcu_x, bus.lcu_y, bus.ipf_offset} !== {3'(lx), 3'(ly), par_mem[lcu][15:0]})
                    bnd_err++;
            end
            if (bus.in_en && gap > 0) begin
                if (gap != 3) gap_err++;
                gap = 0;
            end

            if (glitch_at >= 0 && !glitched && acc_n >= glitch_at) begin
                start        = 1'b1;
                cfg_lcu_size = 2'd0;
                glitched     = 1'b1;
            end else begin
                start = 1'b0;
            end
            bus.busy  = (busy_pct > 0) && (($urandom % 100) < busy_pct);
            acc_prev  = bus.in_en && !bus.busy;
            was_stall = bus.in_en && bus.busy;
            snap      = ipf_side();
            if (acc_prev) begin
                if (acc_n < NPIX) begin
                    modelBeat(acc_n, lsz, addr, lcu, lx, ly);
                    if (bus.din !== img_mem[addr]) din_err++;
                    if ({bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset} !== par_mem[lcu] ||
                        bus.lcu_x !== 3'(lx) || bus.lcu_y !== 3'(ly)) fld_err++;
                    acc_din[acc_n] = bus.din;
                    acc_lx[acc_n]  = bus.lcu_x;
                    acc_ly[acc_n]  = bus.lcu_y;
                    prev_lx  = lx;
                    prev_ly  = ly;
                    prev_off = int'(par_mem[lcu][15:0]);
                    acc_n++;
                    if (acc_n == abort_at) aborted = 1'b1;
                end else begin
                    extra++;
                end
            end
            if (!finished && !aborted) begin
                @(negedge clk);
                cyc++;
            end
        end
        start    = 1'b0;
        bus.busy = 1'b0;

        checkOutput({tag, "_din_errors"}, 64'(din_err), 64'd0);
        checkOutput({tag, "_param_errors"}, 64'(fld_err), 64'd0);
        checkOutput({tag, "_stall_stability_errors"}, 64'(stab_err), 64'd0);
        checkOutput({tag, "_par_addr_errors"}, 64'(paddr_err), 64'd0);

        if (aborted) begin
            @(posedge clk);
            #2;
            reset = 1'b0;
            #1;
            checkOutput({tag, "_reset_all_outputs"}, all_outputs(), 64'd0);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            countQuiet(20, quiet);
            checkOutput({tag, "_quiet_after_reset"}, 64'(quiet), 64'd0);
            return;
        end

        checkOutput({tag, "_finished_in_budget"}, 64'(finished), 64'd1);
        checkOutput({tag, "_beats"}, 64'(acc_n), 64'(NPIX));
        checkOutput({tag, "_extra_beats"}, 64'(extra), 64'd0);
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        checkOutput({tag, "_done_timing_errors"}, 64'(done_err), 64'd0);
        checkOutput({tag, "_gap_errors"}, 64'(gap_err), 64'd0);
        checkOutput({tag, "_boundary_errors"}, 64'(bnd_err), 64'd0);
        checkOutput({tag, "_par_reads"}, 64'(par_cnt), 64'(nl));
        checkOutput({tag, "_img_reads"}, 64'(rd_cnt), 64'(NPIX));
        checkOutput({tag, "_last_img_addr"}, 64'(last_addr), 64'(NPIX - 1));
        checkOutput({tag, "_lcu_size"}, 64'(bus.lcu_size), 64'(eff));
        countQuiet(8, quiet);
        checkOutput({tag, "_quiet_after_done"}, 64'(quiet), 64'd0);
    endtask

    initial begin
        logic [5:0] nn;
        int quiet;

        reset        = 1'b0;
        start        = 1'b0;
        cfg_lcu_size = 2'd0;
        bus.busy     = 1'b0;
        for (int n = 0; n < 64; n++) begin
            nn = 6'(n);
            par_mem[n] = {nn[1:0], nn[4:0], nn[0], 16'hA500 | 16'(nn)};
        end
        for (int a = 0; a < NPIX; a++) img_mem[a] = 8'(a);

        #12;
        checkOutput("reset_all_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        countQuiet(6, quiet);
        checkOutput("idle_no_reads_before_start", 64'(quiet), 64'd0);

        $display("[TB] L=64 ramp image, busy=0");
        applyStimulus("l64_ramp", 2'd2, 0, -1, -1);
        checkOutput("l64_beat0", 64'(acc_din[0]), 64'h00);
        checkOutput("l64_beat1", 64'(acc_din[1]), 64'h01);
        checkOutput("l64_beat2", 64'(acc_din[2]), 64'h02);
        checkOutput("l64_beat64", 64'(acc_din[64]), 64'h80);
        checkOutput("l64_beat4096", 64'(acc_din[4096]), 64'h40);
        checkOutput("l64_beat4096_lcu", 64'({acc_lx[4096], acc_ly[4096]}), 64'({3'd1, 3'd0}));

        for (int a = 0; a < NPIX; a++) img_mem[a] = 8'($urandom);

        $display("[TB] cfg code 3, random busy 50%%, start pulsed mid-frame");
        applyStimulus("cfg3_busy50", 2'd3, 50, -1, 3000);

        $display("[TB] L=16 with reset after 1000 beats");
        applyStimulus("l16_abort", 2'd0, 25, 1000, -1);

        $display("[TB] L=16 full frame after reset");
        applyStimulus("l16_restart", 2'd0, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
